// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO between instruction memory and decode: ready/valid on both
// sides, optional zero-latency bypass when empty, branch flush, and a saturating discard counter.
module instr_prefetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [DATA_W-1:0]        enq_data,
  input  logic [ADDR_W-1:0]        enq_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [DATA_W-1:0]        deq_data,
  output logic [ADDR_W-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         discard_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_BW = PTR_W + 1;
  localparam int SUM_W  = ((CNT_W > CNT_BW) ? CNT_W : CNT_BW) + 1;
  localparam logic BYP  = (BYPASS != 0);
  localparam logic [CNT_W-1:0] DISC_MAX = '1;

  // Handshake: a transfer happens on a side only in a cycle where its valid and ready
  // are both high; flush forces both readies/valids low so nothing moves that cycle.
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_BW-1:0] r_count;
  logic [CNT_W-1:0]  r_discard;

  logic              w_full;
  logic              w_empty;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_byp_fire;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [CNT_BW-1:0] w_count_next;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_disc_next;

  assign w_full  = (r_count == CNT_BW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign enq_ready = ~flush & (~w_full | deq_ready);
  assign deq_valid = ~flush & (~w_empty | (BYP & enq_valid));
  assign deq_data  = (w_empty & BYP) ? enq_data : r_mem_data[r_rd_ptr];
  assign deq_pc    = (w_empty & BYP) ? enq_pc   : r_mem_pc[r_rd_ptr];

  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;
  // A word that passes straight through an empty queue never touches storage.
  assign w_byp_fire = w_empty & BYP & w_enq_fire & w_deq_fire;
  assign w_wr_en    = w_enq_fire & ~w_byp_fire;
  assign w_rd_en    = w_deq_fire & ~w_byp_fire;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_en && !w_rd_en) begin
      w_count_next = r_count + CNT_BW'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_count_next = r_count - CNT_BW'(1);
    end
  end

  assign w_sum       = SUM_W'(r_discard) + SUM_W'(r_count);
  assign w_disc_next = (w_sum > SUM_W'(DISC_MAX)) ? DISC_MAX : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_discard <= '0;
    end else if (flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_discard <= w_disc_next;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr] <= enq_data;
      r_mem_pc[r_wr_ptr]   <= enq_pc;
    end
  end

  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign discard_cnt = r_discard;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: a BYPASS=0/CNT_W=8 and a BYPASS=1/CNT_W=2 instance share
// directed stimulus and are checked every cycle against a queue-based model.
module tb_instr_prefetch_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 4;
  localparam int MAX0   = 255;
  localparam int MAX1   = 3;
  localparam int EW     = DATA_W + ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic enq_valid = 1'b0;
  logic deq_ready = 1'b0;
  logic [DATA_W-1:0] enq_data = '0;
  logic [ADDR_W-1:0] enq_pc = '0;

  logic              er0, dv0, fu0, em0;
  logic [DATA_W-1:0] dd0;
  logic [ADDR_W-1:0] dp0;
  logic [2:0]        c0;
  logic [7:0]        dc0;
  logic              er1, dv1, fu1, em1;
  logic [DATA_W-1:0] dd1;
  logic [ADDR_W-1:0] dp1;
  logic [2:0]        c1;
  logic [1:0]        dc1;

  instr_prefetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(er0),
    .enq_data(enq_data), .enq_pc(enq_pc), .deq_valid(dv0), .deq_ready(deq_ready),
    .deq_data(dd0), .deq_pc(dp0), .count(c0), .full(fu0), .empty(em0), .discard_cnt(dc0));

  instr_prefetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(er1),
    .enq_data(enq_data), .enq_pc(enq_pc), .deq_valid(dv1), .deq_ready(deq_ready),
    .deq_data(dd1), .deq_pc(dp1), .count(c1), .full(fu1), .empty(em1), .discard_cnt(dc1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic model_ok = 1'b0;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  int d0 = 0;
  int d1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the queue holds {pc,data}; bypass (BYPASS=1, empty) hands the word straight over.
  task automatic step0();
    int sz = q0.size();
    logic ef, df;
    if (rst) begin
      q0.delete(); d0 = 0;
    end else if (flush) begin
      d0 = (d0 + sz > MAX0) ? MAX0 : d0 + sz;
      q0.delete();
    end else begin
      ef = enq_valid && (sz < DEPTH || deq_ready);
      df = deq_ready && (sz > 0);
      if (df) void'(q0.pop_front());
      if (ef) q0.push_back({enq_pc, enq_data});
    end
  endtask

  task automatic step1();
    int sz = q1.size();
    logic ef, df;
    if (rst) begin
      q1.delete(); d1 = 0;
    end else if (flush) begin
      d1 = (d1 + sz > MAX1) ? MAX1 : d1 + sz;
      q1.delete();
    end else begin
      ef = enq_valid && (sz < DEPTH || deq_ready);
      df = deq_ready && (sz > 0 || enq_valid);
      if (!(sz == 0 && ef && df)) begin
        if (df) void'(q1.pop_front());
        if (ef) q1.push_back({enq_pc, enq_data});
      end
    end
  endtask

  always @(posedge clk) begin
    step0();
    step1();
    if (rst) model_ok = 1'b1;
  end

  task automatic cmp0();
    int sz = q0.size();
    logic ev_exp;
    chk("d0_count", 64'(c0), 64'(sz));
    chk("d0_full", 64'(fu0), 64'(sz == DEPTH));
    chk("d0_empty", 64'(em0), 64'(sz == 0));
    chk("d0_discard", 64'(dc0), 64'(d0));
    chk("d0_enq_ready", 64'(er0), 64'(!flush && (sz < DEPTH || deq_ready)));
    ev_exp = !flush && (sz > 0);
    chk("d0_deq_valid", 64'(dv0), 64'(ev_exp));
    if (ev_exp) chk("d0_deq_entry", 64'({dp0, dd0}), 64'(q0[0]));
  endtask

  task automatic cmp1();
    int sz = q1.size();
    logic ev_exp;
    logic [EW-1:0] h;
    chk("d1_count", 64'(c1), 64'(sz));
    chk("d1_full", 64'(fu1), 64'(sz == DEPTH));
    chk("d1_empty", 64'(em1), 64'(sz == 0));
    chk("d1_discard", 64'(dc1), 64'(d1));
    chk("d1_enq_ready", 64'(er1), 64'(!flush && (sz < DEPTH || deq_ready)));
    ev_exp = !flush && (sz > 0 || enq_valid);
    chk("d1_deq_valid", 64'(dv1), 64'(ev_exp));
    if (ev_exp) begin
      if (sz > 0) h = q1[0];
      else h = {enq_pc, enq_data};
      chk("d1_deq_entry", 64'({dp1, dd1}), 64'(h));
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp0();
      cmp1();
    end
  end

  task automatic drive(input logic r, input logic f, input logic ev,
                       input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] p, input logic dr);
    rst = r; flush = f; enq_valid = ev; enq_data = d; enq_pc = p; deq_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, base + DATA_W'(i), ADDR_W'(i), 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic do_flush();
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD0000, 7'h7F, 1'b1);
    #1;
    chk("lit_flush_enq_ready0", 64'(er0), 64'd0);
    chk("lit_flush_deq_valid1", 64'(dv1), 64'd0);
    tick();
    idle();
    #1;
    chk("lit_post_flush_count0", 64'(c0), 64'd0);
    chk("lit_post_flush_empty1", 64'(em1), 64'd1);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    tick(); tick();
    idle();
    #1;
    chk("lit_rst_empty", 64'(em0), 64'd1);
    chk("lit_rst_full", 64'(fu0), 64'd0);
    chk("lit_rst_count", 64'(c1), 64'd0);
    chk("lit_rst_deq_valid", 64'(dv0), 64'd0);
    chk("lit_rst_enq_ready", 64'(er1), 64'd1);
    chk("lit_rst_discard", 64'(dc0), 64'd0);

    fill(4, 32'hE3A00001);
    drive(1'b0, 1'b0, 1'b1, 32'hE3A00005, 7'd4, 1'b0);
    #1;
    chk("lit_full0", 64'(fu0), 64'd1);
    chk("lit_full_enq_ready0", 64'(er0), 64'd0);
    chk("lit_full_enq_ready1", 64'(er1), 64'd0);

    for (int j = 0; j < 6; j++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hE3A00005 + DATA_W'(j), ADDR_W'(4 + j), 1'b1);
      #1;
      chk("lit_stream_enq_ready", 64'(er0), 64'd1);
      chk("lit_stream_count", 64'(c0), 64'd4);
      if (j == 0) chk("lit_stream_first", 64'({dp0, dd0}), 64'({7'd0, 32'hE3A00001}));
      if (j == 3) chk("lit_stream_fourth", 64'({dp1, dd1}), 64'({7'd3, 32'hE3A00004}));
      tick();
    end

    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    chk("lit_drain_first", 64'({dp0, dd0}), 64'({7'd6, 32'hE3A00007}));
    repeat (4) tick();
    chk("lit_drained_empty0", 64'(em0), 64'd1);
    chk("lit_drained_empty1", 64'(em1), 64'd1);

    drive(1'b0, 1'b0, 1'b1, 32'hEAFFFFFE, 7'h10, 1'b1);
    #1;
    chk("lit_byp_valid1", 64'(dv1), 64'd1);
    chk("lit_byp_data1", 64'(dd1), 64'hEAFFFFFE);
    chk("lit_byp_pc1", 64'(dp1), 64'h10);
    chk("lit_nobyp_valid0", 64'(dv0), 64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    chk("lit_byp_count1", 64'(c1), 64'd0);
    chk("lit_nobyp_count0", 64'(c0), 64'd1);
    chk("lit_nobyp_late_data", 64'(dd0), 64'hEAFFFFFE);
    tick();
    idle();

    fill(3, 32'h11110000);
    do_flush();
    chk("lit_disc0_a", 64'(dc0), 64'd3);
    chk("lit_disc1_a", 64'(dc1), 64'd3);
    fill(2, 32'h22220000);
    do_flush();
    chk("lit_disc0_b", 64'(dc0), 64'd5);
    chk("lit_disc1_sat_b", 64'(dc1), 64'd3);
    fill(1, 32'h33330000);
    do_flush();
    chk("lit_disc0_c", 64'(dc0), 64'd6);
    chk("lit_disc1_sat_c", 64'(dc1), 64'd3);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, (i % 3) != 0, 32'hA5000000 + DATA_W'(i), ADDR_W'(32 + i), (i % 2) == 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    repeat (5) tick();
    chk("lit_mixed_empty0", 64'(em0), 64'd1);
    chk("lit_mixed_empty1", 64'(em1), 64'd1);

    fill(2, 32'h44440000);
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    tick();
    idle();
    #1;
    chk("lit_rstflush_count0", 64'(c0), 64'd0);
    chk("lit_rstflush_disc0", 64'(dc0), 64'd0);
    chk("lit_rstflush_disc1", 64'(dc1), 64'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
